ltc2624_dual_frame_sender: RTL and testbench
============================================

// Module: ltc2624_dual_frame_sender
// PURPOSE
//  Serialises two 12-bit samples (channel A, channel B) to the LTC2624 quad DAC over SPI.
//  It sits directly downstream of the oscillator pair, in place of the DAC driving stage.
//  Each accepted start sends two 32-bit write-and-update frames, A first and then B.
//  SCK is generated internally from qzt_clk. dac_number marks each completed frame and is usable as a slow clock for the oscillator counters.
// PARAMETERS
//  SCK_HALF_DIV  2        qzt_clk cycles per SCK half-period (2 -> 12.5 MHz SCK); legal range 1..15
//  CS_GAP        2        qzt_clk cycles that DAC_CS is held high between/after frames; legal range 1..15
//  SIGNED_IN     0        1: inputs are two's complement and the MSB is inverted to give offset binary; 0: inputs pass through as-is
//  CMD           4'b0011  LTC2624 command nibble (write to and update n)
//  ADDR_A        4'b0000  DAC address nibble used for va
//  ADDR_B        4'b0001  DAC address nibble used for vb
// PORTS
//  qzt_clk     in   1   system clock, 50 MHz
//  reset       in   1   synchronous, active-high
//  start       in   1   one-cycle request; accepted only when busy=0
//  va          in   12  channel A sample
//  vb          in   12  channel B sample
//  busy        out  1   high from the cycle after accept until done
//  done        out  1   one-cycle pulse after frame B's trailing CS gap
//  dac_number  out  1   0 = last completed frame was B (or idle); 1 = last completed frame was A
//  SPI_SCK     out  1   idle low
//  SPI_MOSI    out  1   MSB first; changes only while SCK is low
//  DAC_CS      out  1   active low; idle high
//  DAC_CLR     out  1   tied high (inactive)
// BEHAVIOUR
//  Reset values: busy=0, done=0, dac_number=0, SPI_SCK=0, SPI_MOSI=0, DAC_CS=1.
//  Reset takes effect on the next edge from any state and aborts any frame in progress.
//  reset and start in the same cycle: reset wins, start is dropped.
//  Accept: start=1 && busy=0. In the accept cycle, va and vb are captured (after the SIGNED_IN conversion).
//  Later input changes do not affect the transfer. start while busy=1 is ignored, not queued.
//  Frame layout, MSB first: {8'h00, CMD, ADDR_x, data[11:0], 4'h0}, 32 bits.
//  FSM states: IDLE -> SETUP_A -> SHIFT_A -> GAP_A -> SETUP_B -> SHIFT_B -> GAP_B -> IDLE.
//  SETUP (1 cycle): DAC_CS=0, MOSI=frame[31], SCK=0.
//  SHIFT: for each of 32 bits, SCK is low for SCK_HALF_DIV cycles, then high for SCK_HALF_DIV cycles.
//   On the SCK falling edge the frame shifts left and MOSI takes the next bit.
//   After the 32nd falling edge, go to GAP.
//  GAP: DAC_CS=1, SCK=0, MOSI=0 for CS_GAP cycles.
//   On entering GAP_A, dac_number is set to 1. On entering GAP_B, dac_number is cleared to 0.
//  Leaving GAP_B: done=1 for exactly one cycle and busy=0 in the same cycle.
//   A start in that same cycle is accepted (back-to-back).
//  Frame length F = 1 + 64*SCK_HALF_DIV + CS_GAP cycles. done is asserted 2*F cycles after the accept cycle.
//   Defaults: F=131, done at accept+262.
//  A new transfer runs every 20 us (1000 cycles), which gives ample margin at the defaults.
//  SCK never glitches. At most one SCK rising edge occurs per CS-low window per bit. No SCK edge occurs while DAC_CS=1.
// STRUCTURE
//  Shared package ltc2624_pkg:
//   - FRAME_W=32
//   - CMD_WRITE_UPDATE=4'b0011
//   - ADDR_DAC_A/B/C/D and ADDR_ALL=4'b1111
//   - function ltc2624_frame(cmd, addr, data12) returning a 32-bit value
//   - state enum localparams.
//  Sub-module spi_frame_shifter: loads a 32-bit word and shifts it out with its SCK divider, bit counter and frame_done.
//   The top-level FSM sequences A/B, captures the inputs, and drives CS, dac_number, busy and done.
// TESTING
//  - Reset, then idle 50 cycles -> DAC_CS=1, SCK=0, MOSI=0, busy=0, done=0, dac_number=0, with no SCK edges.
//  - va=12'hABC, vb=12'h123, start pulse -> the bench samples MOSI on SCK rising edges.
//    Frame 1 must be 32'h0030ABC0 and frame 2 must be 32'h00311230. Each frame has exactly 32 SCK rises with DAC_CS=0.
//  - Defaults: accept at cycle t -> dac_number rises at t+129 and falls at t+260.
//    done pulses at t+262 and is 1 cycle wide.
//  - SIGNED_IN=1, va=12'h800 (-2048), vb=12'h7FF -> the data fields are 12'h000 and 12'hFFF.
//  - start re-pulsed at t+40, and va changed at t+1 -> both ignored: transferred data equals the values captured at t, and only one done occurs.
//  - reset asserted at t+70, mid SHIFT_A -> at t+71: DAC_CS=1, SCK=0, busy=0, dac_number=0.
//    A following start then produces two clean frames.

Source files
------------

// File: rtl/ltc2624_pkg.sv
// ltc2624_pkg: LTC2624 frame constants, FSM state codes and frame builder
package ltc2624_pkg;
  localparam int FRAME_W = 32;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] ADDR_DAC_A = 4'b0000;
  localparam logic [3:0] ADDR_DAC_B = 4'b0001;
  localparam logic [3:0] ADDR_DAC_C = 4'b0010;
  localparam logic [3:0] ADDR_DAC_D = 4'b0011;
  localparam logic [3:0] ADDR_ALL = 4'b1111;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SETUP_A = 3'd1;
  localparam logic [2:0] S_SHIFT_A = 3'd2;
  localparam logic [2:0] S_GAP_A = 3'd3;
  localparam logic [2:0] S_SETUP_B = 3'd4;
  localparam logic [2:0] S_SHIFT_B = 3'd5;
  localparam logic [2:0] S_GAP_B = 3'd6;
  function automatic logic [FRAME_W-1:0] ltc2624_frame(input logic [3:0] cmd, input logic [3:0] addr, input logic [11:0] data12);
    return {8'h00, cmd, addr, data12, 4'h0};
  endfunction
endpackage

// File: rtl/ltc2624_dual_frame_sender_shifter.sv
// spi_frame_shifter: shifts one 32-bit word out MSB first with a divided, glitch-free SCK
module spi_frame_shifter
  import ltc2624_pkg::*;
#(
  parameter int HALF = 2
) (
  input  logic               qzt_clk,
  input  logic               reset,
  input  logic               load,
  input  logic               go,
  input  logic [FRAME_W-1:0] word,
  output logic               sck,
  output logic               mosi,
  output logic               last
);
  logic [FRAME_W-1:0] sr;
  logic [3:0] cnt;
  logic [4:0] bits;
  logic active;
  logic half_end;
  assign half_end = active && cnt == 4'(HALF - 1);
  assign last = half_end && sck && bits == 5'd31;
  // the register drains to zero, so MOSI idles low once the frame is out
  assign mosi = sr[FRAME_W-1];
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      sr <= '0;
      cnt <= '0;
      bits <= '0;
      active <= 1'b0;
      sck <= 1'b0;
    end else if (load) begin
      sr <= word;
      cnt <= '0;
      bits <= '0;
      active <= 1'b0;
      sck <= 1'b0;
    end else if (go) begin
      active <= 1'b1;
      cnt <= '0;
      sck <= 1'b0;
    end else if (half_end) begin
      cnt <= '0;
      sck <= !sck;
      if (sck) begin
        sr <= sr << 1;
        bits <= bits + 5'd1;
        if (bits == 5'd31) active <= 1'b0;
      end
    end else if (active) begin
      cnt <= cnt + 4'd1;
    end
  end
endmodule

// File: rtl/ltc2624_dual_frame_sender.sv
// ltc2624_dual_frame_sender: sends channel A then channel B write-and-update frames to an LTC2624
module ltc2624_dual_frame_sender
  import ltc2624_pkg::*;
#(
  parameter int SCK_HALF_DIV = 2,
  parameter int CS_GAP = 2,
  parameter int SIGNED_IN = 0,
  parameter logic [3:0] CMD = CMD_WRITE_UPDATE,
  parameter logic [3:0] ADDR_A = ADDR_DAC_A,
  parameter logic [3:0] ADDR_B = ADDR_DAC_B
) (
  input  logic        qzt_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] va,
  input  logic [11:0] vb,
  output logic        busy,
  output logic        done,
  output logic        dac_number,
  output logic        SPI_SCK,
  output logic        SPI_MOSI,
  output logic        DAC_CS,
  output logic        DAC_CLR
);
  localparam logic FLIP = SIGNED_IN != 0;
  logic [2:0] state, nxt;
  logic [11:0] vb_q, va_c, vb_c;
  logic [3:0] gap;
  logic gap_end, last, load, go, in_gap;
  logic [FRAME_W-1:0] word;
  assign va_c = {va[11] ^ FLIP, va[10:0]};
  assign vb_c = {vb[11] ^ FLIP, vb[10:0]};
  assign in_gap = state == S_GAP_A || state == S_GAP_B;
  assign gap_end = in_gap && gap == 4'(CS_GAP - 1);
  assign load = (state == S_IDLE && start) || (state == S_GAP_A && gap_end);
  assign go = state == S_SETUP_A || state == S_SETUP_B;
  assign word = state == S_IDLE ? ltc2624_frame(CMD, ADDR_A, va_c) : ltc2624_frame(CMD, ADDR_B, vb_q);
  assign busy = state != S_IDLE;
  assign DAC_CLR = 1'b1;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    nxt = start ? S_SETUP_A : S_IDLE;
      S_SETUP_A: nxt = S_SHIFT_A;
      S_SHIFT_A: nxt = last ? S_GAP_A : S_SHIFT_A;
      S_GAP_A:   nxt = gap_end ? S_SETUP_B : S_GAP_A;
      S_SETUP_B: nxt = S_SHIFT_B;
      S_SHIFT_B: nxt = last ? S_GAP_B : S_SHIFT_B;
      S_GAP_B:   nxt = gap_end ? S_IDLE : S_GAP_B;
      default:   nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state <= S_IDLE;
      vb_q <= '0;
      gap <= '0;
      done <= 1'b0;
      dac_number <= 1'b0;
      DAC_CS <= 1'b1;
    end else begin
      state <= nxt;
      gap <= in_gap ? gap + 4'd1 : 4'd0;
      done <= state == S_GAP_B && gap_end;
      if (state == S_IDLE && start) vb_q <= vb_c;
      if (state == S_SHIFT_A && last) dac_number <= 1'b1;
      if (state == S_SHIFT_B && last) dac_number <= 1'b0;
      // CS is registered from the next state so it never glitches between frames
      DAC_CS <= !(nxt == S_SETUP_A || nxt == S_SHIFT_A || nxt == S_SETUP_B || nxt == S_SHIFT_B);
    end
  end
  spi_frame_shifter #(.HALF(SCK_HALF_DIV)) u_shifter (
    .qzt_clk(qzt_clk),
    .reset(reset),
    .load(load),
    .go(go),
    .word(word),
    .sck(SPI_SCK),
    .mosi(SPI_MOSI),
    .last(last)
  );
endmodule

// File: tb/tb_ltc2624_dual_frame_sender.sv
// tb_ltc2624_dual_frame_sender: randomized self-checking bench against a frame/timing model
module tb_ltc2624_dual_frame_sender;
  logic qzt_clk = 0, reset = 1, start = 0;
  logic [11:0] va = 0, vb = 0;
  logic busy, done, dac_number, sck, mosi, cs, clr;
  logic busy2, done2, dn2, sck2, mosi2, cs2, clr2;
  int total = 0, bad = 0, cyc = 0, sck_bad = 0, rises = 0, dn_rise = -1, dn_fall = -1;
  logic [31:0] cur = 0, cur2 = 0;
  logic [31:0] frames[$], frames2[$];
  int nrises[$], done_cyc[$];
  logic p_sck = 0, p_cs = 1, p_dn = 0, p_sck2 = 0, p_cs2 = 1;
  localparam int F = 1 + 64 * 2 + 2;

  ltc2624_dual_frame_sender dut (
    .qzt_clk(qzt_clk), .reset(reset), .start(start), .va(va), .vb(vb),
    .busy(busy), .done(done), .dac_number(dac_number),
    .SPI_SCK(sck), .SPI_MOSI(mosi), .DAC_CS(cs), .DAC_CLR(clr)
  );
  ltc2624_dual_frame_sender #(.SIGNED_IN(1)) dut2 (
    .qzt_clk(qzt_clk), .reset(reset), .start(start), .va(va), .vb(vb),
    .busy(busy2), .done(done2), .dac_number(dn2),
    .SPI_SCK(sck2), .SPI_MOSI(mosi2), .DAC_CS(cs2), .DAC_CLR(clr2)
  );

  always #10 qzt_clk = !qzt_clk;
  always @(posedge qzt_clk) cyc <= cyc + 1;

  always @(posedge qzt_clk) begin
    #2;
    if (sck && !p_sck) begin
      if (cs) sck_bad++;
      else begin
        cur = {cur[30:0], mosi};
        rises++;
      end
    end
    if (cs && !p_cs) begin
      frames.push_back(cur);
      nrises.push_back(rises);
      cur = 0;
      rises = 0;
    end
    if (dac_number && !p_dn) dn_rise = cyc;
    if (!dac_number && p_dn) dn_fall = cyc;
    if (done) done_cyc.push_back(cyc);
    if (sck2 && !p_sck2 && !cs2) cur2 = {cur2[30:0], mosi2};
    if (cs2 && !p_cs2) begin
      frames2.push_back(cur2);
      cur2 = 0;
    end
    p_sck = sck; p_cs = cs; p_dn = dac_number; p_sck2 = sck2; p_cs2 = cs2;
  end

  function automatic logic [31:0] model_frame(input logic [3:0] addr, input logic [11:0] data);
    return (32'd3 << 20) + (32'(addr) << 16) + (32'(data) << 4);
  endfunction

  task automatic step();
    @(posedge qzt_clk);
    #1;
  endtask

  task automatic clear_q();
    frames.delete(); frames2.delete(); nrises.delete(); done_cyc.delete();
    sck_bad = 0; dn_rise = -1; dn_fall = -1;
  endtask

  task automatic kick(input logic [11:0] a, input logic [11:0] b, output int t);
    va = a; vb = b; start = 1; t = cyc + 1;
    step();
    start = 0;
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (done_cyc.size() < n && k < 1000) begin step(); k++; end
    if (done_cyc.size() < n) begin
      total++; bad++;
      $display("FAIL wait_done: got %0d done pulses, need %0d", done_cyc.size(), n);
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    logic [5:0] seen = 0;
    reset = 1;
    repeat (3) step();
    reset = 0;
    clear_q();
    repeat (50) begin
      step();
      seen |= {sck, mosi, !cs, busy, done, dac_number};
    end
    total++; if (seen !== 6'b0) begin bad++; $display("FAIL reset_idle: seen=%b need 000000", seen); end
    total++; if (cs !== 1'b1) begin bad++; $display("FAIL reset_cs: got %b need 1", cs); end
    total++; if (clr !== 1'b1) begin bad++; $display("FAIL reset_clr: got %b need 1", clr); end
    total++; if (sck_bad !== 0 || frames.size() !== 0) begin bad++; $display("FAIL reset_edges: sck_bad=%0d frames=%0d need 0", sck_bad, frames.size()); end
  endtask

  task automatic test_frames();
    int t;
    clear_q();
    kick(12'hABC, 12'h123, t);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_accept: got %b need 1", busy); end
    wait_done(1);
    repeat (5) step();
    total++; if (frames.size() !== 2) begin bad++; $display("FAIL frame_count: got %0d need 2", frames.size()); end
    total++; if (frames[0] !== 32'h0030ABC0) begin bad++; $display("FAIL frame_a: got %h need 0030abc0", frames[0]); end
    total++; if (frames[1] !== 32'h00311230) begin bad++; $display("FAIL frame_b: got %h need 00311230", frames[1]); end
    total++; if (nrises[0] !== 32 || nrises[1] !== 32) begin bad++; $display("FAIL sck_rises: got %0d/%0d need 32/32", nrises[0], nrises[1]); end
    total++; if (dn_rise !== t + 129) begin bad++; $display("FAIL dn_rise: got %0d need %0d", dn_rise, t + 129); end
    total++; if (dn_fall !== t + 260) begin bad++; $display("FAIL dn_fall: got %0d need %0d", dn_fall, t + 260); end
    total++; if (done_cyc[0] !== t + 2 * F) begin bad++; $display("FAIL done_time: got %0d need %0d", done_cyc[0], t + 2 * F); end
    total++; if (done_cyc.size() !== 1) begin bad++; $display("FAIL done_width: got %0d pulse cycles need 1", done_cyc.size()); end
    total++; if (sck_bad !== 0) begin bad++; $display("FAIL sck_while_cs_high: got %0d need 0", sck_bad); end
  endtask

  task automatic test_random();
    int t;
    logic [11:0] a, b;
    for (int i = 0; i < 4; i++) begin
      clear_q();
      a = 12'($urandom); b = 12'($urandom);
      kick(a, b, t);
      wait_done(1);
      total++; if (frames[0] !== model_frame(4'd0, a) || frames[1] !== model_frame(4'd1, b)) begin
        bad++; $display("FAIL random_%0d: got %h %h need %h %h", i, frames[0], frames[1], model_frame(4'd0, a), model_frame(4'd1, b));
      end
      total++; if (frames2[0] !== model_frame(4'd0, 12'(a + 12'd2048)) || frames2[1] !== model_frame(4'd1, 12'(b + 12'd2048))) begin
        bad++; $display("FAIL random_signed_%0d: got %h %h", i, frames2[0], frames2[1]);
      end
    end
  endtask

  task automatic test_signed();
    int t;
    clear_q();
    kick(12'h800, 12'h7FF, t);
    wait_done(1);
    total++; if (frames2[0][15:4] !== 12'h000 || frames2[1][15:4] !== 12'hFFF) begin
      bad++; $display("FAIL signed_data: got %h %h need 000 fff", frames2[0][15:4], frames2[1][15:4]);
    end
    total++; if (frames[0][15:4] !== 12'h800 || frames[1][15:4] !== 12'h7FF) begin
      bad++; $display("FAIL unsigned_data: got %h %h need 800 7ff", frames[0][15:4], frames[1][15:4]);
    end
  endtask

  task automatic test_ignore();
    int t;
    logic [11:0] a, b;
    clear_q();
    a = 12'($urandom); b = 12'($urandom);
    kick(a, b, t);
    va = ~a; vb = ~b;
    while (cyc < t + 39) step();
    start = 1;
    step();
    start = 0;
    wait_done(1);
    repeat (20) step();
    total++; if (frames[0] !== model_frame(4'd0, a) || frames[1] !== model_frame(4'd1, b)) begin
      bad++; $display("FAIL ignore_data: got %h %h need %h %h", frames[0], frames[1], model_frame(4'd0, a), model_frame(4'd1, b));
    end
    total++; if (done_cyc.size() !== 1 || busy !== 1'b0) begin bad++; $display("FAIL ignore_start: done=%0d busy=%b need 1/0", done_cyc.size(), busy); end
  endtask

  task automatic test_reset_mid();
    int t;
    logic [11:0] a, b;
    clear_q();
    kick(12'h555, 12'hAAA, t);
    while (cyc < t + 70) step();
    reset = 1;
    step();
    total++; if ({cs, sck, busy, dac_number} !== 4'b1000) begin
      bad++; $display("FAIL reset_mid: cs/sck/busy/dn=%b need 1000", {cs, sck, busy, dac_number});
    end
    reset = 0;
    step();
    clear_q();
    a = 12'($urandom); b = 12'($urandom);
    kick(a, b, t);
    wait_done(1);
    total++; if (frames.size() !== 2 || frames[0] !== model_frame(4'd0, a) || frames[1] !== model_frame(4'd1, b)) begin
      bad++; $display("FAIL after_reset: n=%0d got %h %h", frames.size(), frames[0], frames[1]);
    end
  endtask

  task automatic test_back_to_back();
    int t, t2, k;
    logic [11:0] a, b;
    clear_q();
    kick(12'h321, 12'h654, t);
    k = 0;
    while (done !== 1'b1 && k < 1000) begin step(); k++; end
    total++; if (busy !== 1'b0 || cyc !== t + 2 * F) begin bad++; $display("FAIL b2b_done: busy=%b at %0d need 0 at %0d", busy, cyc, t + 2 * F); end
    a = 12'($urandom); b = 12'($urandom);
    kick(a, b, t2);
    wait_done(2);
    total++; if (done_cyc[1] !== t2 + 2 * F || t2 !== t + 2 * F + 1) begin bad++; $display("FAIL b2b_time: got %0d need %0d", done_cyc[1], t + 4 * F + 1); end
    total++; if (frames.size() !== 4 || frames[2] !== model_frame(4'd0, a) || frames[3] !== model_frame(4'd1, b)) begin
      bad++; $display("FAIL b2b_frames: n=%0d got %h %h", frames.size(), frames[2], frames[3]);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_random();
    test_signed();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
